uart_tx_scheduler: RTL

- Shares one tx_uart instance between G_NB_REQ byte requesters in the UART test-bench library, using round-robin arbitration.
- Sequences each frame as a start pulse to the transmitter, then a wait for completion, then a programmable inter-frame gap.
- Enforces a completion timeout so a stuck transmitter cannot hang the bench.
- Sits between bench drivers (valid/ready) and a tx_uart (start_tx/tx_data/tx_done).

---
 rtl/uart_tb_pkg.sv | 13 +
 rtl/uart_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_tb_pkg.sv
// Shared types and constants for the UART test-bench transmit scheduler.
package uart_tb_pkg;

  localparam int C_FRAME_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } t_uart_sched_state;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant,
// wrapping around, so the previously granted requester has lowest priority.
module uart_rr_arbiter #(
  parameter int G_NB_REQ = 4
) (
  input  logic [G_NB_REQ-1:0]         req,
  input  logic [$clog2(G_NB_REQ)-1:0] last_grant,
  output logic [$clog2(G_NB_REQ)-1:0] grant,
  output logic                        any_req
);

  localparam int IDX_W = $clog2(G_NB_REQ);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= G_NB_REQ) s = s - G_NB_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int i = G_NB_REQ; i >= 1; i--) begin
      if (req[wrap_idx(last_grant, i)]) grant = wrap_idx(last_grant, i);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one tx_uart between several byte requesters: round-robin grant, start pulse,
// wait for the done edge (with timeout), then a programmable idle gap.
module uart_tx_scheduler
  import uart_tb_pkg::*;
#(
  parameter int G_NB_REQ     = 4,
  parameter int G_DATA_WIDTH = 8,
  parameter int G_GAP_WIDTH  = 16,
  parameter int G_TIMEOUT    = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_enable,
  input  logic [G_GAP_WIDTH-1:0]           i_gap_cycles,
  input  logic [G_NB_REQ-1:0]              i_req_valid,
  input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_req_data,
  output logic [G_NB_REQ-1:0]              o_req_ready,
  output logic                             o_start_tx,
  output logic [G_DATA_WIDTH-1:0]          o_tx_data,
  input  logic                             i_tx_done,
  output logic                             o_busy,
  output logic [$clog2(G_NB_REQ)-1:0]      o_grant_id,
  output logic [C_FRAME_CNT_WIDTH-1:0]     o_frame_cnt,
  output logic                             o_timeout_err
);

  localparam int IDX_W = $clog2(G_NB_REQ);
  localparam int TO_W  = $clog2(G_TIMEOUT + 1);

  t_uart_sched_state    state, state_nxt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     arb_grant;
  logic                 any_req;
  logic                 done_p;
  logic                 done_edge;
  logic                 timeout_hit;
  logic                 grant_en;
  logic                 frame_end;
  logic                 frame_inc;
  logic [TO_W-1:0]      to_cnt;
  logic [G_GAP_WIDTH-1:0] gap_cnt;

  uart_rr_arbiter #(
    .G_NB_REQ(G_NB_REQ)
  ) u_arb (
    .req       (i_req_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .any_req   (any_req)
  );

  // A done level already high when WAIT_DONE is entered must not complete the frame.
  assign done_edge   = i_tx_done & ~done_p;
  assign timeout_hit = (to_cnt == TO_W'(G_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    grant_en      = 1'b0;
    frame_end     = 1'b0;
    frame_inc     = 1'b0;
    o_start_tx    = 1'b0;
    o_req_ready   = '0;
    o_timeout_err = 1'b0;
    o_busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (i_enable && any_req) begin
          grant_en  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        o_start_tx              = 1'b1;
        o_req_ready[o_grant_id] = 1'b1;
        state_nxt               = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Done takes priority over a simultaneous timeout.
        if (done_edge) begin
          frame_end = 1'b1;
          frame_inc = 1'b1;
        end else if (timeout_hit) begin
          frame_end     = 1'b1;
          o_timeout_err = 1'b1;
        end
        if (frame_end) state_nxt = (i_gap_cycles == '0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt <= G_GAP_WIDTH'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_p      <= 1'b0;
      last_grant  <= IDX_W'(G_NB_REQ - 1);
      o_grant_id  <= '0;
      o_tx_data   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      o_frame_cnt <= '0;
    end else begin
      done_p <= i_tx_done;
      if (grant_en) begin
        last_grant <= arb_grant;
        o_grant_id <= arb_grant;
        o_tx_data  <= i_req_data[int'(arb_grant)*G_DATA_WIDTH +: G_DATA_WIDTH];
      end
      if (state == ST_START)          to_cnt <= '0;
      else if (state == ST_WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);
      if (frame_inc) o_frame_cnt <= o_frame_cnt + C_FRAME_CNT_WIDTH'(1);
      // Gap length is latched at frame end; later changes only affect the next frame.
      if (frame_end)              gap_cnt <= i_gap_cycles;
      else if (state == ST_GAP)   gap_cnt <= gap_cnt - G_GAP_WIDTH'(1);
    end
  end

endmodule
